mux_nx1_rr_reg: RTL and testbench
=================================

// Module: mux_nx1_rr_reg
// PURPOSE
//   Parametrised N-input, W-bit registered multiplexer with valid/ready handshake.
//   - Two modes: fixed select (explicit sel, like a plain mux) or round-robin
//     arbitration across requesting inputs.
//   - One output register stage (latency 1), with stall/backpressure support.
//   - Sits between multiple producer stages and one shared consumer, e.g. a
//     shared result bus or a memory port.
// PARAMETERS
//   N   4  number of input channels (N >= 2)
//   W   8  data width per channel
//   SW  $clog2(N)  select/index width (derived, not overridden)
// PORTS
//   clk        in   1     clock; all state updates on posedge
//   rst        in   1     asynchronous, active-high reset
//   mode       in   1     0 = fixed select via sel; 1 = round-robin arbitration
//   sel        in   SW    channel index used when mode=0
//   in_valid   in   N     per-channel request; bit i belongs to channel i
//   in_data    in   N*W   channel i data occupies in_data[i*W +: W]
//   in_ready   out  N     one-hot (or zero) acceptance; transfer when in_valid[i]&in_ready[i]
//   out_valid  out  1     output register holds a valid word
//   out_data   out  W     registered data
//   out_sel    out  SW    index of the channel that supplied out_data
//   out_ready  in   1     consumer accepts; transfer when out_valid&out_ready
// BEHAVIOUR
//   Reset (async, rst=1): out_valid=0, out_data=0, out_sel=0, rr pointer ptr=0;
//     in_ready=0 while rst asserted. Reset mid-transfer discards the held word.
//   load_en = !out_valid | out_ready   (register empty, or draining this cycle).
//   Grant g (combinational, from current in_valid/mode/sel/ptr):
//     mode=0: grant sel if sel<N and in_valid[sel]; else no grant.
//       sel>=N never grants.
//     mode=1: first i with in_valid[i]=1, searching ptr, ptr+1, ..., N-1, 0, ...,
//       ptr-1 (wraps mod N); none if in_valid==0.
//   in_ready[i] = load_en & grant_valid & (g==i); at most one bit set.
//     in_ready may depend on in_valid (no combinational path from in_ready to in_valid).
//   On posedge:
//     if load_en & grant_valid: out_data<=in_data[g], out_sel<=g, out_valid<=1.
//     elif load_en: out_valid<=0 (out_data/out_sel keep last value).
//     else (stall: out_valid & !out_ready): all output regs hold.
//   ptr update: only on an accepted input transfer in mode=1: ptr <= (g==N-1) ? 0 : g+1.
//     Mode=0 transfers leave ptr unchanged.
//   Latency: input accepted in cycle t appears on out_* in cycle t+1.
//   Throughput: 1 word/cycle while out_ready=1 (simultaneous drain + load allowed).
//   Fairness: mode=1 with all N requesting continuously serves 0,1,...,N-1,0,...
//   mode/sel may change any cycle; they affect only the next grant, never the held word.
//   Input withdrawing in_valid without a transfer is legal; no state is retained for it.
//   out_data stable while out_valid & !out_ready.
// TESTING
//   1. Reset: assert rst mid-stream with out_valid=1
//      -> out_valid=0, out_data=0, out_sel=0, in_ready=0 immediately (async);
//         after release, first grant starts at ptr=0.
//   2. Fixed mode: N=4, W=8, mode=0, sel=2, in_valid=4'b1111, data i=8'hA0+i, out_ready=1
//      -> in_ready=4'b0100 each cycle; out_data=8'hA2, out_sel=2 one cycle later.
//      sel=2 with in_valid[2]=0 -> in_ready=0, out_valid drops next cycle.
//   3. Round-robin: mode=1, in_valid=4'b1111 held, out_ready=1
//      -> out_sel sequence 0,1,2,3,0 on consecutive cycles.
//      in_valid=4'b1001 -> 0,3,0,3.
//   4. Backpressure: mode=1, out_ready=0 for 3 cycles after first load
//      -> in_ready=0, out_data/out_sel frozen, ptr unchanged;
//         out_ready=1 -> drain and next grant in the same cycle.
//   5. Wrap/boundary: ptr=3 with in_valid=4'b0001 -> grant 0, ptr becomes 1.
//      Grant of channel 3 -> ptr wraps to 0.
//   6. Mode switch: alternate mode every cycle with random in_valid/out_ready
//      -> scoreboard: every accepted word appears once, in order, with the correct
//         out_sel; at most one in_ready bit set.

Source files
------------

// File: rtl/mux_nx1_rr_reg.sv
// N-input registered mux with valid/ready handshake.
// Fixed-select or round-robin grant feeds a single output register.
module mux_nx1_rr_reg #(
    parameter  int N  = 4,
    parameter  int W  = 8,
    localparam int SW = $clog2(N)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           mode,
    input  logic [SW-1:0]  sel,
    input  logic [N-1:0]   in_valid,
    input  logic [N*W-1:0] in_data,
    output logic [N-1:0]   in_ready,
    output logic           out_valid,
    output logic [W-1:0]   out_data,
    output logic [SW-1:0]  out_sel,
    input  logic           out_ready
);

    logic [SW-1:0] ptr;
    logic [SW-1:0] g;
    logic          gv;
    logic          load_en;
    logic          acc;

    assign load_en = !out_valid || out_ready;
    assign acc     = load_en && gv;

    // Round-robin search starts at ptr and wraps modulo N.
    always_comb begin
        int j;
        gv = 1'b0;
        g  = '0;
        j  = 0;
        if (!mode) begin
            if (int'(sel) < N) begin
                if (in_valid[sel]) begin
                    gv = 1'b1;
                    g  = sel;
                end
            end
        end else begin
            for (int k = 0; k < N; k++) begin
                j = int'(ptr) + k;
                if (j >= N) j = j - N;
                if (!gv && in_valid[j]) begin
                    gv = 1'b1;
                    g  = SW'(j);
                end
            end
        end
    end

    always_comb begin
        in_ready = '0;
        if (!rst && acc) in_ready[g] = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_sel   <= '0;
            ptr       <= '0;
        end else begin
            if (acc) begin
                out_valid <= 1'b1;
                out_data  <= in_data[int'(g)*W +: W];
                out_sel   <= g;
                if (mode) ptr <= (g == SW'(N-1)) ? '0 : g + 1'b1;
            end else if (load_en) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_mux_nx1_rr_reg.sv
// Directed table plus randomised mode-switch scoreboard
// for mux_nx1_rr_reg.
module tb_mux_nx1_rr_reg;

    localparam int N  = 4;
    localparam int W  = 8;
    localparam int SW = 2;

    logic           clk = 1'b0;
    logic           rst;
    logic           mode;
    logic [SW-1:0]  sel;
    logic [N-1:0]   in_valid;
    logic [N*W-1:0] in_data;
    logic [N-1:0]   in_ready;
    logic           out_valid;
    logic [W-1:0]   out_data;
    logic [SW-1:0]  out_sel;
    logic           out_ready;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic          mode;
        logic [SW-1:0] sel;
        logic [N-1:0]  iv;
        logic          ordy;
        logic [N-1:0]  eir;
        logic          eov;
        logic [SW-1:0] esel;
        logic [W-1:0]  edata;
    } vec_t;

    vec_t tbl[$];

    typedef struct {
        logic [W-1:0]  d;
        logic [SW-1:0] s;
    } word_t;

    word_t sb[$];

    mux_nx1_rr_reg #(.N(N), .W(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .mode      (mode),
        .sel       (sel),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_sel   (out_sel),
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     name, act, exp, $time);
        end
    endtask

    task automatic add(input logic m, input logic [SW-1:0] s,
                       input logic [N-1:0] iv, input logic r,
                       input logic [N-1:0] eir, input logic eov,
                       input logic [SW-1:0] es, input logic [W-1:0] ed);
        vec_t v;
        v.mode = m; v.sel = s; v.iv = iv; v.ordy = r;
        v.eir = eir; v.eov = eov; v.esel = es; v.edata = ed;
        tbl.push_back(v);
    endtask

    task automatic fixed_data();
        for (int i = 0; i < N; i++) in_data[i*W +: W] = 8'hA0 + 8'(i);
    endtask

    initial begin
        logic [SW-1:0] mptr;
        logic          mov;
        logic          gv;
        logic [SW-1:0] gi;
        logic [N-1:0]  eir;
        logic          le;
        int            k;
        word_t         w;

        rst = 1'b1; mode = 1'b0; sel = '0; in_valid = '0;
        out_ready = 1'b0;
        fixed_data();
        #2;
        chk("rst_ov", 32'(out_valid), 0);
        chk("rst_od", 32'(out_data), 0);
        chk("rst_os", 32'(out_sel), 0);
        chk("rst_ir", 32'(in_ready), 0);
        @(posedge clk); #1;
        rst = 1'b0;

        // fixed select
        add(0, 2, 4'b1111, 1, 4'b0100, 1, 2, 8'hA2);
        add(0, 2, 4'b1111, 1, 4'b0100, 1, 2, 8'hA2);
        add(0, 2, 4'b1011, 1, 4'b0000, 0, 2, 8'hA2);
        // round robin, all requesting
        add(1, 0, 4'b1111, 1, 4'b0001, 1, 0, 8'hA0);
        add(1, 0, 4'b1111, 1, 4'b0010, 1, 1, 8'hA1);
        add(1, 0, 4'b1111, 1, 4'b0100, 1, 2, 8'hA2);
        add(1, 0, 4'b1111, 1, 4'b1000, 1, 3, 8'hA3);
        add(1, 0, 4'b1111, 1, 4'b0001, 1, 0, 8'hA0);
        // two requesters, ptr=1
        add(1, 0, 4'b1001, 1, 4'b1000, 1, 3, 8'hA3);
        add(1, 0, 4'b1001, 1, 4'b0001, 1, 0, 8'hA0);
        add(1, 0, 4'b1001, 1, 4'b1000, 1, 3, 8'hA3);
        add(1, 0, 4'b1001, 1, 4'b0001, 1, 0, 8'hA0);
        // backpressure: hold 3 cycles, then drain+load
        add(1, 0, 4'b1111, 0, 4'b0000, 1, 0, 8'hA0);
        add(1, 0, 4'b1111, 0, 4'b0000, 1, 0, 8'hA0);
        add(1, 0, 4'b1111, 0, 4'b0000, 1, 0, 8'hA0);
        add(1, 0, 4'b1111, 1, 4'b0010, 1, 1, 8'hA1);
        // wrap: reach ptr=3, lone request on 0 -> ptr=1
        add(1, 0, 4'b0100, 1, 4'b0100, 1, 2, 8'hA2);
        add(1, 0, 4'b0001, 1, 4'b0001, 1, 0, 8'hA0);
        add(1, 0, 4'b1101, 1, 4'b0100, 1, 2, 8'hA2);
        add(1, 0, 4'b1000, 1, 4'b1000, 1, 3, 8'hA3);
        add(1, 0, 4'b1111, 1, 4'b0001, 1, 0, 8'hA0);
        // fixed grant leaves ptr alone
        add(0, 3, 4'b1111, 1, 4'b1000, 1, 3, 8'hA3);
        add(1, 0, 4'b1111, 1, 4'b0010, 1, 1, 8'hA1);
        add(1, 0, 4'b0000, 1, 4'b0000, 0, 1, 8'hA1);
        // empty register loads even with out_ready low
        add(0, 0, 4'b0001, 0, 4'b0001, 1, 0, 8'hA0);

        foreach (tbl[i]) begin
            mode = tbl[i].mode; sel = tbl[i].sel;
            in_valid = tbl[i].iv; out_ready = tbl[i].ordy;
            #3;
            chk($sformatf("v%0d_ir", i), 32'(in_ready), 32'(tbl[i].eir));
            @(posedge clk); #1;
            chk($sformatf("v%0d_ov", i), 32'(out_valid), 32'(tbl[i].eov));
            chk($sformatf("v%0d_os", i), 32'(out_sel), 32'(tbl[i].esel));
            chk($sformatf("v%0d_od", i), 32'(out_data), 32'(tbl[i].edata));
        end

        // async reset while holding a word under stall; ptr was 2
        mode = 1'b1; in_valid = 4'b1111; out_ready = 1'b0;
        rst = 1'b1;
        #1;
        chk("mid_rst_ov", 32'(out_valid), 0);
        chk("mid_rst_od", 32'(out_data), 0);
        chk("mid_rst_os", 32'(out_sel), 0);
        chk("mid_rst_ir", 32'(in_ready), 0);
        @(posedge clk); #1;
        rst = 1'b0; out_ready = 1'b1;
        #3;
        chk("post_rst_ir", 32'(in_ready), 32'(4'b0001));
        @(posedge clk); #1;
        chk("post_rst_os", 32'(out_sel), 0);
        chk("post_rst_od", 32'(out_data), 32'(8'hA0));

        // alternating mode with random traffic against a reference model
        mptr = 1; mov = 1'b1;
        sb.delete();
        w.d = 8'hA0; w.s = 0;
        sb.push_back(w);
        for (int c = 0; c < 300; c++) begin
            mode = c[0];
            sel = SW'($urandom_range(0, N-1));
            in_valid = N'($urandom_range(0, 15));
            out_ready = ($urandom_range(0, 3) != 0);
            for (int i = 0; i < N; i++) in_data[i*W +: W] = W'($urandom);
            #3;
            gv = 1'b0; gi = '0;
            if (!mode) begin
                gv = in_valid[sel]; gi = sel;
            end else begin
                k = int'(mptr);
                repeat (N) begin
                    if (!gv && in_valid[k]) begin
                        gv = 1'b1; gi = SW'(k);
                    end
                    k = (k + 1) % N;
                end
            end
            le = !mov || out_ready;
            eir = (le && gv) ? (N'(1) << gi) : '0;
            chk("rnd_ir", 32'(in_ready), 32'(eir));
            chk("rnd_onehot", 32'($countones(in_ready) <= 1), 1);
            chk("rnd_ov", 32'(out_valid), 32'(mov));
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    chk("rnd_sb_empty", 1, 0);
                end else begin
                    w = sb.pop_front();
                    chk("rnd_od", 32'(out_data), 32'(w.d));
                    chk("rnd_os", 32'(out_sel), 32'(w.s));
                end
            end
            if (le && gv) begin
                w.d = in_data[int'(gi)*W +: W]; w.s = gi;
                sb.push_back(w);
                if (mode) mptr = (gi == SW'(N-1)) ? '0 : gi + 1'b1;
            end
            if (le) mov = gv;
            @(posedge clk); #1;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
